// File: rtl/psum_ofifo.sv
// psum_ofifo
//   Output-side buffer for the MAC array. Each of the col columns pushes its
//   own partial sum into its own FIFO whenever its write strobe fires, so the
//   columns may arrive on staggered cycles. A row is released only when every
//   column FIFO holds at least one entry. Downstream therefore always reads
//   col-wide, column-aligned rows.
//
// Ports
//   clk        in   1             rising-edge clock
//   reset      in   1             asynchronous, active-high reset
//   wr         in   col           per-column push strobe (bit i = column i)
//   in         in   col*bw_psum   column i data in in[bw_psum*(i+1)-1:bw_psum*i]
//   rd         in   1             row pop request
//   out        out  col*bw_psum   registered popped row, same packing as in
//   o_valid    out  1             every column FIFO non-empty
//   o_full     out  1             any column FIFO full
//   o_ready    out  1             ~o_full
//   o_overflow out  1             sticky: a push was dropped on a full column

module psum_ofifo #(
  parameter int col     = 8,
  parameter int bw      = 4,
  parameter int bw_psum = 2*bw+4,
  parameter int depth   = 16,
  parameter int ptr_w   = $clog2(depth)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [col-1:0]         wr,
  input  logic [col*bw_psum-1:0] in,
  input  logic                   rd,
  output logic [col*bw_psum-1:0] out,
  output logic                   o_valid,
  output logic                   o_full,
  output logic                   o_ready,
  output logic                   o_overflow
);

  logic [col-1:0]         empty;
  logic [col-1:0]         full;
  logic [col-1:0]         drop;
  logic [col*bw_psum-1:0] head_row;
  logic                   pop;

  assign o_valid = &(~empty);
  assign o_full  = |full;
  assign o_ready = ~o_full;

  // A pop is only honoured when a whole row exists; rd on a partial row is ignored.
  assign pop = rd & o_valid;

  for (genvar i = 0; i < col; i++) begin : g_col
    logic [ptr_w:0]       wr_ptr;
    logic [ptr_w:0]       rd_ptr;
    logic [bw_psum-1:0]   mem [depth];
    logic                 push;

    // Pointers carry one extra wrap bit so full and empty can be told apart.
    assign empty[i] = (wr_ptr == rd_ptr);
    assign full[i]  = (wr_ptr[ptr_w] != rd_ptr[ptr_w]) &&
                      (wr_ptr[ptr_w-1:0] == rd_ptr[ptr_w-1:0]);

    // A same-cycle pop frees the head slot, so a full column still accepts a push.
    assign push    = wr[i] & (~full[i] | pop);
    assign drop[i] = wr[i] & full[i] & ~pop;

    assign head_row[i*bw_psum +: bw_psum] = mem[rd_ptr[ptr_w-1:0]];

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
      end
    end

    // Storage is not reset; the pointers alone define what is valid.
    always_ff @(posedge clk) begin
      if (push) mem[wr_ptr[ptr_w-1:0]] <= in[i*bw_psum +: bw_psum];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out <= '0;
    end else if (pop) begin
      out <= head_row;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      o_overflow <= 1'b0;
    end else if (|drop) begin
      o_overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_psum_ofifo.sv
// tb_psum_ofifo
//   Self-checking bench for psum_ofifo. A queue-per-column reference model
//   tracks buffered entries, the registered output row and the sticky
//   overflow flag; every cycle the DUT outputs are compared against it.
//   Directed scenarios are followed by a randomized phase.

module tb_psum_ofifo;

  localparam int COL   = 8;
  localparam int BWP   = 12;
  localparam int DEPTH = 16;
  localparam int W     = COL*BWP;

  logic           clk;
  logic           reset;
  logic [COL-1:0] wr;
  logic [W-1:0]   in;
  logic           rd;
  logic [W-1:0]   out;
  logic           o_valid;
  logic           o_full;
  logic           o_ready;
  logic           o_overflow;

  int errors;
  int checks;

  logic [BWP-1:0] mq [COL][$];
  logic [W-1:0]   out_m;
  logic           ovf_m;

  psum_ofifo dut (
    .clk        (clk),
    .reset      (reset),
    .wr         (wr),
    .in         (in),
    .rd         (rd),
    .out        (out),
    .o_valid    (o_valid),
    .o_full     (o_full),
    .o_ready    (o_ready),
    .o_overflow (o_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit model_valid();
    for (int i = 0; i < COL; i++)
      if (mq[i].size() == 0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit model_full();
    for (int i = 0; i < COL; i++)
      if (mq[i].size() == DEPTH) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < COL; i++) mq[i].delete();
    out_m = '0;
    ovf_m = 1'b0;
  endtask

  task automatic check_all(input string tag);
    checkOutput({tag, ".out"},      out,        out_m);
    checkOutput({tag, ".valid"},    W'(o_valid),    W'(model_valid()));
    checkOutput({tag, ".full"},     W'(o_full),     W'(model_full()));
    checkOutput({tag, ".ready"},    W'(o_ready),    W'(!model_full()));
    checkOutput({tag, ".overflow"}, W'(o_overflow), W'(ovf_m));
  endtask

  // Drive one cycle of inputs, advance the model, then check after the edge.
  task automatic applyStimulus(input string tag, input logic [COL-1:0] w,
                               input logic [W-1:0] d, input logic r);
    bit pop;
    @(negedge clk);
    wr = w;
    in = d;
    rd = r;
    pop = r && model_valid();
    if (pop)
      for (int i = 0; i < COL; i++) out_m[i*BWP +: BWP] = mq[i].pop_front();
    for (int i = 0; i < COL; i++) begin
      if (w[i]) begin
        if (mq[i].size() < DEPTH) mq[i].push_back(d[i*BWP +: BWP]);
        else ovf_m = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  function automatic logic [W-1:0] row_of(input int base);
    logic [W-1:0] v;
    for (int i = 0; i < COL; i++) v[i*BWP +: BWP] = BWP'(base + i);
    return v;
  endfunction

  function automatic logic [W-1:0] rand_row();
    logic [W-1:0] v;
    for (int i = 0; i < COL; i++) v[i*BWP +: BWP] = BWP'($urandom);
    return v;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    wr = '0;
    rd = 1'b0;
    model_clear();
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_all("reset");
  endtask

  initial begin
    errors = 0;
    checks = 0;
    wr = '0;
    in = '0;
    rd = 1'b0;
    reset = 1'b1;
    model_clear();
    repeat (2) @(posedge clk);
    do_reset();

    // 1: one full-width write, then pop it
    applyStimulus("t1.wr", 8'hFF, row_of(1), 1'b0);
    applyStimulus("t1.rd", 8'h00, '0, 1'b1);
    checkOutput("t1.row", out, {12'd8, 12'd7, 12'd6, 12'd5, 12'd4, 12'd3, 12'd2, 12'd1});

    // 2: staggered column writes, row appears only after the last column
    for (int i = 0; i < COL; i++)
      applyStimulus("t2.stagger", COL'(1) << i, row_of(16'h40 + 8*i), 1'b0);
    applyStimulus("t2.rd", 8'h00, '0, 1'b1);

    // 3: overfill column 0, then prove its first 16 entries are intact
    do_reset();
    for (int k = 0; k < DEPTH + 1; k++)
      applyStimulus("t3.fill0", 8'h01, row_of(16'h100 + k), 1'b0);
    for (int k = 0; k < DEPTH; k++)
      applyStimulus("t3.fillrest", 8'hFE, row_of(16'h200 + 8*k), 1'b0);
    for (int k = 0; k < DEPTH; k++)
      applyStimulus("t3.drain", 8'h00, '0, 1'b1);

    // 4: all columns full, then streaming push+pop for 40 cycles
    do_reset();
    for (int k = 0; k < DEPTH; k++)
      applyStimulus("t4.fill", 8'hFF, rand_row(), 1'b0);
    for (int k = 0; k < 40; k++)
      applyStimulus("t4.stream", 8'hFF, rand_row(), 1'b1);
    for (int k = 0; k < DEPTH; k++)
      applyStimulus("t4.drain", 8'h00, '0, 1'b1);

    // 5: pop request while empty must not change anything
    applyStimulus("t5.rd_empty", 8'h00, '0, 1'b1);
    applyStimulus("t5.rd_empty2", 8'h00, '0, 1'b1);

    // 6: async reset between edges discards buffered rows
    for (int k = 0; k < 3; k++)
      applyStimulus("t6.push", 8'hFF, rand_row(), 1'b0);
    applyStimulus("t6.pop", 8'h00, '0, 1'b1);
    @(negedge clk);
    wr = '0;
    rd = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    model_clear();
    check_all("t6.async");
    @(negedge clk);
    reset = 1'b0;
    applyStimulus("t6.newwr", 8'hFF, row_of(16'h7A0), 1'b0);
    applyStimulus("t6.newrd", 8'h00, '0, 1'b1);

    // Randomized phase: random strobes, data and pop requests
    do_reset();
    for (int k = 0; k < 400; k++)
      applyStimulus("rand", COL'($urandom), rand_row(), 1'($urandom_range(0, 2) != 0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
